// File: rtl/arbiter.sv
// Dual-issue dispatch arbiter: routes each accepted instruction to FIFO_1 or FIFO_2
// using override, register-ownership steering, then alternating load balance.
module arbiter #(
    parameter bit INIT_TARGET = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        fifo1_full,
    input  logic        fifo2_full,
    output logic [31:0] FIFO_1,
    output logic        fifo1_wr,
    output logic [31:0] FIFO_2,
    output logic        fifo2_wr,
    output logic        conflict
);

    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready.
    // instr_ready depends on instr itself, because the full flag consulted is the chosen target's.

    logic [1:0] ovr;
    logic [4:0] src1, src2, dest;
    logic       imm;
    logic       unused_bits;

    assign ovr         = instr[28:27];
    assign src1        = instr[20:16];
    assign src2        = instr[15:11];
    assign imm         = instr[10];
    assign dest        = instr[4:0];
    assign unused_bits = ^{instr[31:29], instr[26:21], instr[9:5]};

    // Register ownership as two one-hot vectors; a register is never owned by both.
    logic [31:0] own_f1, own_f2;
    logic        toggle;

    logic dep1, dep2, forced, free, both_dep, target, accept;

    always_comb begin
        dep1     = own_f1[src1] | (!imm && own_f1[src2]) | own_f1[dest];
        dep2     = own_f2[src1] | (!imm && own_f2[src2]) | own_f2[dest];
        forced   = ovr[1];
        free     = !forced && !dep1 && !dep2;
        both_dep = !forced && dep1 && dep2;
        target   = toggle;
        if (forced) begin
            target = ovr[0];
        end else if (dep1 && !dep2) begin
            target = 1'b0;
        end else if (dep2 && !dep1) begin
            target = 1'b1;
        end else if (both_dep) begin
            // Tie-break on the first owned operand: src1, then src2 (if read), then dest.
            if (own_f1[src1] || own_f2[src1]) begin
                target = own_f2[src1];
            end else if (!imm && (own_f1[src2] || own_f2[src2])) begin
                target = own_f2[src2];
            end else begin
                target = own_f2[dest];
            end
        end
    end

    assign instr_ready = target ? !fifo2_full : !fifo1_full;
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_f1   <= '0;
            own_f2   <= '0;
            toggle   <= INIT_TARGET;
            FIFO_1   <= '0;
            FIFO_2   <= '0;
            fifo1_wr <= 1'b0;
            fifo2_wr <= 1'b0;
            conflict <= 1'b0;
        end else begin
            fifo1_wr <= accept && !target;
            fifo2_wr <= accept && target;
            conflict <= accept && both_dep;
            if (accept) begin
                if (target) begin
                    FIFO_2 <= instr;
                end else begin
                    FIFO_1 <= instr;
                end
                own_f1[dest] <= !target;
                own_f2[dest] <= target;
                if (free) begin
                    toggle <= !toggle;
                end
            end
        end
    end

endmodule

// File: tb/tb_arbiter.sv
// Directed bench for the dispatch arbiter; expected dispatches are queued by the
// driver and matched by a monitor one edge after acceptance.
module tb_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        fifo1_full;
    logic        fifo2_full;
    logic [31:0] FIFO_1;
    logic        fifo1_wr;
    logic [31:0] FIFO_2;
    logic        fifo2_wr;
    logic        conflict;

    arbiter #(.INIT_TARGET(1'b0)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fifo1_full(fifo1_full), .fifo2_full(fifo2_full),
        .FIFO_1(FIFO_1), .fifo1_wr(fifo1_wr), .FIFO_2(FIFO_2), .fifo2_wr(fifo2_wr),
        .conflict(conflict)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard entry: {target, conflict, data}; target 0 = FIFO_1
    logic [33:0] exp_q[$];
    logic [31:0] model_f1, model_f2;
    int n_pass;
    int n_fail;
    int n_total;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] ovr, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic imm,
                                       input logic [4:0] d);
        return {3'b000, ovr, 6'b0, s1, s2, imm, 5'b0, d};
    endfunction

    // Monitor: one sample per edge, after the registered outputs settle
    always @(posedge clk) begin
        logic [33:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[33]) model_f2 = e[31:0];
            else       model_f1 = e[31:0];
            check("wr1", fifo1_wr, !e[33]);
            check("wr2", fifo2_wr, e[33]);
            check("conflict", conflict, e[32]);
        end else begin
            check("idle_strobes", {fifo1_wr, fifo2_wr}, 0);
            check("idle_conflict", conflict, 0);
        end
        check("fifo1_data", FIFO_1, model_f1);
        check("fifo2_data", FIFO_2, model_f2);
    end

    // Driver tasks
    task automatic send(input logic [31:0] w, input logic tgt, input logic conf);
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        #1;
        check("ready", instr_ready, 1);
        exp_q.push_back({tgt, conf, w});
        @(posedge clk);
        #2;
        instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        instr_valid = 1'b0;
        model_f1 = '0;
        model_f2 = '0;
        #1;
        check("rst_fifo1", FIFO_1, 0);
        check("rst_fifo2", FIFO_2, 0);
        check("rst_strobes", {fifo1_wr, fifo2_wr, conflict}, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        reset = 1'b1; instr = '0; instr_valid = 1'b0;
        fifo1_full = 1'b0; fifo2_full = 1'b0;
        model_f1 = '0; model_f2 = '0;
        #12;
        check("init_fifo1", FIFO_1, 0);
        check("init_fifo2", FIFO_2, 0);
        check("init_strobes", {fifo1_wr, fifo2_wr, conflict}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Free stream alternates starting at FIFO_1
        send(32'h00045678, 1'b0, 1'b0);
        send(32'h0005678a, 1'b1, 1'b0);
        send(32'h000678ab, 1'b0, 1'b0);
        send(32'h00078abc, 1'b1, 1'b0);
        idle(2);

        // Overrides leave the toggle alone
        do_reset();
        send(32'h10000801, 1'b0, 1'b0);
        send(32'h10000803, 1'b0, 1'b0);
        send(32'h18000807, 1'b1, 1'b0);
        send(32'h1800080F, 1'b1, 1'b0);
        send(mk(2'b00, 5'd20, 5'd0, 1'b1, 5'd22), 1'b0, 1'b0);
        send(mk(2'b00, 5'd23, 5'd0, 1'b1, 5'd24), 1'b1, 1'b0);
        idle(1);

        // Dependency chain
        do_reset();
        send(32'h00108815, 1'b0, 1'b0);
        send(32'h2010A815, 1'b0, 1'b0);
        send(32'h2010AC15, 1'b0, 1'b0);
        send(32'h2030AC01, 1'b1, 1'b0);
        idle(1);

        // Conflicts: src1 owner wins, then src2 owner when src1 is unowned
        do_reset();
        send(mk(2'b00, 5'd10, 5'd0, 1'b1, 5'd1), 1'b0, 1'b0);
        send(mk(2'b00, 5'd11, 5'd0, 1'b1, 5'd2), 1'b1, 1'b0);
        send(mk(2'b00, 5'd1, 5'd2, 1'b0, 5'd3), 1'b0, 1'b1);
        idle(1);
        send(mk(2'b00, 5'd12, 5'd2, 1'b0, 5'd1), 1'b1, 1'b1);
        idle(2);

        // Backpressure on the free target holds the toggle
        do_reset();
        @(negedge clk);
        fifo1_full = 1'b1;
        instr = mk(2'b00, 5'd4, 5'd0, 1'b1, 5'd5);
        instr_valid = 1'b1;
        #1;
        check("bp_not_ready", instr_ready, 0);
        @(negedge clk);
        #1;
        check("bp_still_not_ready", instr_ready, 0);
        instr_valid = 1'b0;
        fifo1_full = 1'b0;
        send(mk(2'b00, 5'd4, 5'd0, 1'b1, 5'd5), 1'b0, 1'b0);
        send(mk(2'b00, 5'd7, 5'd0, 1'b1, 5'd8), 1'b1, 1'b0);
        idle(1);

        // Asynchronous reset between edges while a strobe is high
        do_reset();
        send(mk(2'b00, 5'd9, 5'd0, 1'b1, 5'd5), 1'b0, 1'b0);
        send(mk(2'b00, 5'd9, 5'd0, 1'b1, 5'd6), 1'b1, 1'b0);
        #1;
        reset = 1'b1;
        model_f1 = '0;
        model_f2 = '0;
        #1;
        check("async_fifo1", FIFO_1, 0);
        check("async_fifo2", FIFO_2, 0);
        check("async_strobes", {fifo1_wr, fifo2_wr, conflict}, 0);
        @(negedge clk);
        reset = 1'b0;
        send(mk(2'b00, 5'd6, 5'd6, 1'b0, 5'd7), 1'b0, 1'b0);
        idle(2);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
